me_search_ctrl: RTL and testbench
=================================

# me_search_ctrl

Sequencer for the basic-layer integer motion-search datapath (`Basic_layer_search`) in ME_DMT. It accepts a start command, streams the reference window and the current 32x32 block from fetch-side valid/ready channels into the datapath, and drives `ref_begin_prepare` / `pe_begin_prepare` in the required order. It watches the datapath's column/row position counters to detect end of search, emits per-position SAD strobes for the downstream best-candidate selector, and reports done and reference-underrun status.

## Interface
- `REF_PRELOAD_ROWS`, 64: reference rows (256-bit beats) loaded before the current block.
- `CUR_BEATS`, 16: 512-bit beats forming the current 32x32 block.
- `SEARCH_COLS`, 32: last column = `SEARCH_COLS`-1; must be ≤ 32.
- `SEARCH_ROWS`, 64: last row = `SEARCH_ROWS`-1; must be ≤ 128.

- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle command; sampled only in IDLE.
- `busy` out 1: high from start acceptance to DONE inclusive.
- `done` out 1: one-cycle pulse at search end.
- `underrun` out 1: sticky, set on a SEARCH cycle with `ref_in_valid`=0; cleared on accepted `start`.
- `ref_in_valid` in 1, `ref_in_ready` out 1, `ref_in_data` in 256: reference row channel.
- `cur_in_valid` in 1, `cur_in_ready` out 1, `cur_in_data` in 512: current-block channel.
- `ref_input` out 256: registered reference row to datapath.
- `current_64pixels` out 512: registered current pixels to datapath.
- `ref_begin_prepare` out 1, `pe_begin_prepare` out 1: datapath phase enables.
- `search_column_count` in 5, `search_row_count` in 7: datapath position.
- `sad_strobe` out 1: one-cycle pulse when the datapath position advances; SAD buses are valid that cycle.

## Operation
- FSM states: IDLE, REF_LOAD, CUR_LOAD, SEARCH, DONE.
- IDLE: all readies low, prepares low. `start`=1 → REF_LOAD, clear counters and `underrun`.
- REF_LOAD: `ref_in_ready`=1, `ref_begin_prepare`=1. Each handshake: `ref_input` ← `ref_in_data`, `ref_cnt`++. On handshake with `ref_cnt`=`REF_PRELOAD_ROWS`-1 → CUR_LOAD. No handshake → hold.
- CUR_LOAD: `ref_begin_prepare` stays 1, `ref_in_ready`=0, `cur_in_ready`=1, `pe_begin_prepare`=1. Each handshake: `current_64pixels` ← `cur_in_data`, `cur_cnt`++. Last beat (`CUR_BEATS`-1) → SEARCH.
- SEARCH: both prepares 1, `ref_in_ready`=1, `cur_in_ready`=0. The datapath cannot stall, so one row per cycle is expected; a cycle with `ref_in_valid`=0 sets `underrun` and holds `ref_input`. Exit when the sampled position equals (`SEARCH_COLS`-1, `SEARCH_ROWS`-1) and `sad_strobe` fires for it → DONE.
- DONE: one cycle; `done`=1, prepares drop to 0 on leaving; → IDLE.
- `sad_strobe`: register the previous {row,col}; pulse in SEARCH when the current value differs from it. The previous value is preset to all-ones on SEARCH entry, so position (0,0) strobes.
- `start` outside IDLE is ignored, with no queuing.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE; `busy`, `done`, `underrun`, readies, prepares, `sad_strobe` = 0; `ref_input`, `current_64pixels` = 0; counters 0. Reset mid-operation aborts immediately, with no done pulse.
- Start latency: `start` at edge N → `busy`, `ref_in_ready`, `ref_begin_prepare` high after edge N+1.
- The data register updates on the same edge as its handshake; datapath sees new data one cycle after the handshake.
- Minimum preload: `REF_PRELOAD_ROWS` + `CUR_BEATS` cycles with always-valid sources.
- `done` asserts the cycle after the final `sad_strobe`; `busy` falls with `done`.
- All outputs are registered except the readies, which decode from state only and never from `valid`.

## Structure
- Package `me_ctrl_pkg`: state enum, `REF_W`=256, `CUR_W`=512, `COL_W`=5, `ROW_W`=7, default parameter constants.
- Single module, with no sub-module required. An optional `me_beat_counter` (terminal-count counter with clear/enable) is instantiated twice if used.

## Test plan
- Nominal run: always-valid sources; `start` at cycle 2 → `ref_begin_prepare` rises at 3, `pe_begin_prepare` rises at 67, SEARCH entry at 83. A datapath model counting col 0..31 × row 0..63 gives 2048 `sad_strobe` pulses, then `done` once, with `underrun`=0.
- Back-pressure in load: `ref_in_valid` toggling 50% → exactly 64 rows accepted and `ref_input` matches the last accepted beat; `cur_in_ready`=0 until then.
- Underrun: drop `ref_in_valid` for 1 cycle in SEARCH → `underrun`=1 and `ref_input` held; `underrun` stays set through `done` and clears on the next `start`.
- Ignored start: pulse `start` during CUR_LOAD and SEARCH → no state change and a single `done`.
- Reset mid-SEARCH: `rst_n`=0 for one edge at position (5,10) → every output is 0 next cycle, with no `done`; a fresh `start` runs cleanly.
- Parameter corner: `SEARCH_COLS`=1, `SEARCH_ROWS`=1, `CUR_BEATS`=1 → one strobe, then `done`.

Source files
------------

// File: rtl/me_ctrl_pkg.sv
// Shared widths, default geometry and state encoding for the basic-layer
// motion-search sequencer.
package me_ctrl_pkg;

    localparam int unsigned REF_W = 256;
    localparam int unsigned CUR_W = 512;
    localparam int unsigned COL_W = 5;
    localparam int unsigned ROW_W = 7;
    localparam int unsigned POS_W = ROW_W + COL_W;

    localparam int unsigned DEF_REF_PRELOAD_ROWS = 64;
    localparam int unsigned DEF_CUR_BEATS        = 16;
    localparam int unsigned DEF_SEARCH_COLS      = 32;
    localparam int unsigned DEF_SEARCH_ROWS      = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REF_LOAD,
        ST_CUR_LOAD,
        ST_SEARCH,
        ST_DONE
    } me_state_t;

    // Packed {row,col} of the final search position.
    function automatic logic [POS_W-1:0] last_pos(input int unsigned cols,
                                                   input int unsigned rows);
        return {ROW_W'(rows - 1), COL_W'(cols - 1)};
    endfunction

endpackage

// File: rtl/me_beat_counter.sv
// Terminal-count beat counter: counts enabled beats, flags the last one,
// wraps to zero after it.
module me_beat_counter #(
    parameter int unsigned COUNT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int unsigned CW = (COUNT > 1) ? $clog2(COUNT) : 1;

    logic [CW-1:0] cnt;

    assign last = (cnt == CW'(COUNT - 1));

    // Beat count: cleared on reset or command start, advanced per beat.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/me_search_ctrl.sv
// Sequencer for the basic-layer integer motion search: preloads reference
// rows and the current block, then streams rows while watching the datapath
// position to strobe SADs and detect end of search.
module me_search_ctrl
    import me_ctrl_pkg::*;
#(
    parameter int unsigned REF_PRELOAD_ROWS = DEF_REF_PRELOAD_ROWS,
    parameter int unsigned CUR_BEATS        = DEF_CUR_BEATS,
    parameter int unsigned SEARCH_COLS      = DEF_SEARCH_COLS,
    parameter int unsigned SEARCH_ROWS      = DEF_SEARCH_ROWS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             underrun,
    input  logic             ref_in_valid,
    output logic             ref_in_ready,
    input  logic [REF_W-1:0] ref_in_data,
    input  logic             cur_in_valid,
    output logic             cur_in_ready,
    input  logic [CUR_W-1:0] cur_in_data,
    output logic [REF_W-1:0] ref_input,
    output logic [CUR_W-1:0] current_64pixels,
    output logic             ref_begin_prepare,
    output logic             pe_begin_prepare,
    input  logic [COL_W-1:0] search_column_count,
    input  logic [ROW_W-1:0] search_row_count,
    output logic             sad_strobe
);

    localparam logic [POS_W-1:0] LAST_POS = last_pos(SEARCH_COLS, SEARCH_ROWS);

    me_state_t        state;
    me_state_t        next_state;
    logic             ref_hs;
    logic             cur_hs;
    logic             load_start;
    logic             ref_last;
    logic             cur_last;
    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] prev_pos;

    assign pos        = {search_row_count, search_column_count};
    assign ref_hs     = ref_in_valid & ref_in_ready;
    assign cur_hs     = cur_in_valid & cur_in_ready;
    assign load_start = (state == ST_IDLE) & start;

    me_beat_counter #(
        .COUNT(REF_PRELOAD_ROWS)
    ) u_ref_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (load_start),
        .en   (ref_hs & (state == ST_REF_LOAD)),
        .last (ref_last)
    );

    me_beat_counter #(
        .COUNT(CUR_BEATS)
    ) u_cur_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (load_start),
        .en   (cur_hs),
        .last (cur_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and ready decode; readies depend on state only.
    // Search ends in the cycle the final position's strobe is visible, so
    // prev_pos then holds exactly the position that strobed.
    always_comb begin
        next_state   = state;
        ref_in_ready = 1'b0;
        cur_in_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) next_state = ST_REF_LOAD;
            end
            ST_REF_LOAD: begin
                ref_in_ready = 1'b1;
                if (ref_in_valid && ref_last) next_state = ST_CUR_LOAD;
            end
            ST_CUR_LOAD: begin
                cur_in_ready = 1'b1;
                if (cur_in_valid && cur_last) next_state = ST_SEARCH;
            end
            ST_SEARCH: begin
                ref_in_ready = 1'b1;
                if (sad_strobe && (prev_pos == LAST_POS)) next_state = ST_DONE;
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Registered status, phase enables, data capture and position tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy              <= 1'b0;
            done              <= 1'b0;
            underrun          <= 1'b0;
            ref_begin_prepare <= 1'b0;
            pe_begin_prepare  <= 1'b0;
            sad_strobe        <= 1'b0;
            ref_input         <= '0;
            current_64pixels  <= '0;
            prev_pos          <= '1;
        end else begin
            busy              <= (next_state != ST_IDLE);
            done              <= (next_state == ST_DONE);
            ref_begin_prepare <= (next_state != ST_IDLE);
            pe_begin_prepare  <= (next_state == ST_CUR_LOAD) ||
                                 (next_state == ST_SEARCH)   ||
                                 (next_state == ST_DONE);

            if (ref_hs) ref_input <= ref_in_data;
            if (cur_hs) current_64pixels <= cur_in_data;

            if (load_start) begin
                underrun <= 1'b0;
            end else if ((state == ST_SEARCH) && !ref_in_valid) begin
                underrun <= 1'b1;
            end

            sad_strobe <= (state == ST_SEARCH) && (pos != prev_pos);

            if (state == ST_CUR_LOAD) begin
                prev_pos <= '1;
            end else if (state == ST_SEARCH) begin
                prev_pos <= pos;
            end
        end
    end

endmodule

// File: tb/tb_me_search_ctrl.sv
// Directed bench for me_search_ctrl: nominal run, load back-pressure,
// underrun, ignored starts, mid-search reset and a 1x1 geometry instance.
module tb_me_search_ctrl;
    import me_ctrl_pkg::*;

    localparam int W_PE     = 0;
    localparam int W_SEARCH = 1;
    localparam int W_DONE   = 2;
    localparam int W_POS    = 3;
    localparam int W_CDONE  = 4;

    localparam logic [REF_W-1:0] C_REF_DATA = {8{32'hA5C3_0F1E}};
    localparam logic [CUR_W-1:0] C_CUR_DATA = {16{32'h1234_8765}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, start, ref_in_valid, cur_in_valid;
    logic [REF_W-1:0] ref_in_data;
    logic [CUR_W-1:0] cur_in_data;
    logic             busy, done, underrun, ref_in_ready, cur_in_ready;
    logic             ref_begin_prepare, pe_begin_prepare, sad_strobe;
    logic [REF_W-1:0] ref_input;
    logic [CUR_W-1:0] current_64pixels;
    logic [COL_W-1:0] col = '0;
    logic [ROW_W-1:0] row = '0;
    logic [31:0]      ref_seq = '0;
    logic [31:0]      cur_seq = '0;

    logic             c_start, c_busy, c_done, c_underrun, c_ref_in_ready, c_cur_in_ready;
    logic             c_ref_bp, c_pe_bp, c_sad_strobe;
    logic [REF_W-1:0] c_ref_input;
    logic [CUR_W-1:0] c_cur_pix;

    int n_checks = 0;
    int n_err    = 0;

    assign ref_in_data = {8{ref_seq}};
    assign cur_in_data = {16{cur_seq}};

    me_search_ctrl #(
        .REF_PRELOAD_ROWS(64),
        .CUR_BEATS       (16),
        .SEARCH_COLS     (32),
        .SEARCH_ROWS     (64)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .busy               (busy),
        .done               (done),
        .underrun           (underrun),
        .ref_in_valid       (ref_in_valid),
        .ref_in_ready       (ref_in_ready),
        .ref_in_data        (ref_in_data),
        .cur_in_valid       (cur_in_valid),
        .cur_in_ready       (cur_in_ready),
        .cur_in_data        (cur_in_data),
        .ref_input          (ref_input),
        .current_64pixels   (current_64pixels),
        .ref_begin_prepare  (ref_begin_prepare),
        .pe_begin_prepare   (pe_begin_prepare),
        .search_column_count(col),
        .search_row_count   (row),
        .sad_strobe         (sad_strobe)
    );

    me_search_ctrl #(
        .REF_PRELOAD_ROWS(4),
        .CUR_BEATS       (1),
        .SEARCH_COLS     (1),
        .SEARCH_ROWS     (1)
    ) dut_corner (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (c_start),
        .busy               (c_busy),
        .done               (c_done),
        .underrun           (c_underrun),
        .ref_in_valid       (1'b1),
        .ref_in_ready       (c_ref_in_ready),
        .ref_in_data        (C_REF_DATA),
        .cur_in_valid       (1'b1),
        .cur_in_ready       (c_cur_in_ready),
        .cur_in_data        (C_CUR_DATA),
        .ref_input          (c_ref_input),
        .current_64pixels   (c_cur_pix),
        .ref_begin_prepare  (c_ref_bp),
        .pe_begin_prepare   (c_pe_bp),
        .search_column_count(5'd0),
        .search_row_count   (7'd0),
        .sad_strobe         (c_sad_strobe)
    );

    // Source sequence numbers advance on each accepted beat.
    always @(posedge clk) begin
        if (ref_in_valid && ref_in_ready) ref_seq <= ref_seq + 32'd1;
        if (cur_in_valid && cur_in_ready) cur_seq <= cur_seq + 32'd1;
    end

    // Datapath position model: idle at (0,0) without pe prepare, one position
    // per accepted search row, parked on the last position.
    always @(posedge clk) begin
        if (!pe_begin_prepare) begin
            col <= '0;
            row <= '0;
        end else if (ref_in_valid && ref_in_ready && !(col == 5'd31 && row == 7'd63)) begin
            if (col == 5'd31) begin
                col <= '0;
                row <= row + 7'd1;
            end else begin
                col <= col + 5'd1;
            end
        end
    end

    int   cyc = 0;
    int   n_strobe = 0, n_done = 0, c_strobe_n = 0, c_done_n = 0;
    int   strobe_cyc = 0, done_cyc = 0, c_strobe_cyc = 0, c_done_cyc = 0;
    int   ref_rise = 0, pe_rise = 0, search_rise = 0, start_cyc = 0;
    logic prev_ref_bp = 1'b0, prev_pe = 1'b0, prev_srch = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (sad_strobe) begin n_strobe <= n_strobe + 1; strobe_cyc <= cyc; end
        if (done) begin n_done <= n_done + 1; done_cyc <= cyc; end
        if (c_sad_strobe) begin c_strobe_n <= c_strobe_n + 1; c_strobe_cyc <= cyc; end
        if (c_done) begin c_done_n <= c_done_n + 1; c_done_cyc <= cyc; end
        if (ref_begin_prepare && !prev_ref_bp) ref_rise <= cyc;
        if (pe_begin_prepare && !prev_pe) pe_rise <= cyc;
        if ((ref_in_ready && pe_begin_prepare) && !prev_srch) search_rise <= cyc;
        prev_ref_bp <= ref_begin_prepare;
        prev_pe     <= pe_begin_prepare;
        prev_srch   <= ref_in_ready && pe_begin_prepare;
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_for(input int what, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            case (what)
                W_PE:     ok = pe_begin_prepare;
                W_SEARCH: ok = ref_in_ready && pe_begin_prepare;
                W_DONE:   ok = done;
                W_POS:    ok = (col == 5'd5) && (row == 7'd10);
                default:  ok = c_done;
            endcase
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 512'(busy), 512'(1'b0));
        check({tag, "_done"}, 512'(done), 512'(1'b0));
        check({tag, "_underrun"}, 512'(underrun), 512'(1'b0));
        check({tag, "_ref_ready"}, 512'(ref_in_ready), 512'(1'b0));
        check({tag, "_cur_ready"}, 512'(cur_in_ready), 512'(1'b0));
        check({tag, "_ref_bp"}, 512'(ref_begin_prepare), 512'(1'b0));
        check({tag, "_pe_bp"}, 512'(pe_begin_prepare), 512'(1'b0));
        check({tag, "_strobe"}, 512'(sad_strobe), 512'(1'b0));
        check({tag, "_ref_input"}, 512'(ref_input), 512'(0));
        check({tag, "_cur_pix"}, current_64pixels, 512'(0));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: run did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit               ok;
        int               s0, d0, cur_hi;
        logic [31:0]      seq0;
        logic [REF_W-1:0] held;

        rst_n = 1'b0; start = 1'b0; c_start = 1'b0;
        ref_in_valid = 1'b0; cur_in_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        check_all_zero("rst");
        rst_n = 1'b1;
        ref_in_valid = 1'b1;
        cur_in_valid = 1'b1;

        // Nominal run with always-valid sources.
        s0 = n_strobe; d0 = n_done;
        pulse_start();
        wait_for(W_DONE, 3000, ok);
        check("nom_done_seen", 512'(ok), 512'(1'b1));
        check("nom_underrun", 512'(underrun), 512'(1'b0));
        check("nom_busy_at_done", 512'(busy), 512'(1'b1));
        @(posedge clk); #1;
        check("nom_busy_after", 512'(busy), 512'(1'b0));
        check("nom_prep_after", 512'({ref_begin_prepare, pe_begin_prepare}), 512'(2'b00));
        check("nom_ref_lat", 512'(ref_rise - start_cyc), 512'(1));
        check("nom_pe_lat", 512'(pe_rise - ref_rise), 512'(64));
        check("nom_search_lat", 512'(search_rise - ref_rise), 512'(80));
        check("nom_strobes", 512'(n_strobe - s0), 512'(2048));
        check("nom_dones", 512'(n_done - d0), 512'(1));
        check("nom_done_after_strobe", 512'(done_cyc - strobe_cyc), 512'(1));
        check("nom_cur_pix", current_64pixels, {16{32'd15}});
        check("nom_ref_input", 512'(ref_input), 512'({8{ref_seq - 32'd1}}));

        // Reference back-pressure during preload.
        seq0 = ref_seq; cur_hi = 0;
        ref_in_valid = 1'b0;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            ref_in_valid = i[0];
            @(negedge clk);
            ok = pe_begin_prepare;
            if (!ok && cur_in_ready) cur_hi++;
            if (!ok) begin @(posedge clk); #1; end
        end
        check("bp_cur_phase", 512'(ok), 512'(1'b1));
        check("bp_cur_ready_early", 512'(cur_hi), 512'(0));
        check("bp_rows", 512'(ref_seq - seq0), 512'(64));
        check("bp_ref_input", 512'(ref_input), 512'({8{seq0 + 32'd63}}));
        ref_in_valid = 1'b1;
        wait_for(W_DONE, 3000, ok);
        check("bp_done_seen", 512'(ok), 512'(1'b1));
        @(posedge clk); #1;

        // One-cycle underrun in search.
        s0 = n_strobe; d0 = n_done;
        pulse_start();
        wait_for(W_SEARCH, 200, ok);
        check("ur_search_seen", 512'(ok), 512'(1'b1));
        repeat (10) @(posedge clk); #1;
        held = ref_input;
        ref_in_valid = 1'b0;
        @(posedge clk); #1;
        check("ur_set", 512'(underrun), 512'(1'b1));
        check("ur_ref_held", 512'(ref_input), 512'(held));
        ref_in_valid = 1'b1;
        wait_for(W_DONE, 3000, ok);
        check("ur_done_seen", 512'(ok), 512'(1'b1));
        check("ur_sticky_at_done", 512'(underrun), 512'(1'b1));
        @(posedge clk); #1;
        check("ur_strobes", 512'(n_strobe - s0), 512'(2048));
        check("ur_dones", 512'(n_done - d0), 512'(1));

        // Starts during CUR_LOAD and SEARCH are ignored.
        s0 = n_strobe; d0 = n_done;
        pulse_start();
        check("ign_underrun_clr", 512'(underrun), 512'(1'b0));
        wait_for(W_PE, 200, ok);
        check("ign_pe_seen", 512'(ok), 512'(1'b1));
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_for(W_SEARCH, 200, ok);
        check("ign_search_seen", 512'(ok), 512'(1'b1));
        repeat (50) @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_for(W_DONE, 3000, ok);
        check("ign_done_seen", 512'(ok), 512'(1'b1));
        repeat (5) @(posedge clk); #1;
        check("ign_search_lat", 512'(search_rise - ref_rise), 512'(80));
        check("ign_strobes", 512'(n_strobe - s0), 512'(2048));
        check("ign_dones", 512'(n_done - d0), 512'(1));
        check("ign_idle", 512'(busy), 512'(1'b0));

        // Reset at position (5,10), then a fresh run.
        d0 = n_done;
        pulse_start();
        wait_for(W_POS, 1000, ok);
        check("mr_pos_seen", 512'(ok), 512'(1'b1));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_all_zero("mr");
        repeat (20) @(posedge clk); #1;
        check("mr_no_done", 512'(n_done - d0), 512'(0));
        s0 = n_strobe; d0 = n_done;
        pulse_start();
        wait_for(W_DONE, 3000, ok);
        check("mr_rerun_done", 512'(ok), 512'(1'b1));
        @(posedge clk); #1;
        check("mr_rerun_strobes", 512'(n_strobe - s0), 512'(2048));
        check("mr_rerun_dones", 512'(n_done - d0), 512'(1));

        // 1x1 search with a single current beat.
        s0 = c_strobe_n; d0 = c_done_n;
        @(posedge clk); #1; c_start = 1'b1;
        @(posedge clk); #1; c_start = 1'b0;
        wait_for(W_CDONE, 100, ok);
        check("cor_done_seen", 512'(ok), 512'(1'b1));
        repeat (3) @(posedge clk); #1;
        check("cor_strobes", 512'(c_strobe_n - s0), 512'(1));
        check("cor_dones", 512'(c_done_n - d0), 512'(1));
        check("cor_done_after_strobe", 512'(c_done_cyc - c_strobe_cyc), 512'(1));
        check("cor_idle", 512'({c_busy, c_ref_bp, c_pe_bp, c_underrun}), 512'(4'b0000));
        check("cor_readies", 512'({c_ref_in_ready, c_cur_in_ready}), 512'(2'b00));
        check("cor_ref_input", 512'(c_ref_input), 512'(C_REF_DATA));
        check("cor_cur_pix", c_cur_pix, C_CUR_DATA);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
